// File: rtl/debounce_fsm.sv
// Switch debouncer: synchronizer, stability counter and a four-state Moore FSM
// producing a clean, registered level for the downstream edge detector.
module debounce_fsm #(
  parameter int unsigned STABLE_CYCLES = 1_000_000,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic db,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Encoding is {db, busy}, so both outputs come straight from state flops.
  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_t;

  state_t                 state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sw_s;

  // Synchronizer chain; only the last stage is used by the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sw};
    end
  end

  assign sw_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ZERO;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // A revert of sw_s always wins over the terminal count.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      ZERO: begin
        if (sw_s) begin
          state_d = WAIT1;
          cnt_d   = '0;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_d = ZERO;
        end else if (cnt == CNT_LAST) begin
          state_d = ONE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_d = WAIT0;
          cnt_d   = '0;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          state_d = ONE;
        end else if (cnt == CNT_LAST) begin
          state_d = ZERO;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  assign db   = state[1];
  assign busy = state[0];

endmodule

// File: tb/tb_debounce_fsm.sv
// Directed bench for debounce_fsm with STABLE_CYCLES=4, SYNC_STAGES=2.
module tb_debounce_fsm;

  logic clk;
  logic rst;
  logic sw;
  logic db;
  logic busy;

  int nvec;
  int nerr;

  typedef struct packed {
    logic sw;
    logic db;
    logic busy;
  } vec_t;

  vec_t vecs[$];

  debounce_fsm #(
    .STABLE_CYCLES(4),
    .SYNC_STAGES  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw),
    .db  (db),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic d, input logic b);
    vec_t v;
    v.sw   = s;
    v.db   = d;
    v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic add_n(input logic s, input logic d, input logic b, input int n);
    for (int i = 0; i < n; i++) add(s, d, b);
  endtask

  // Drive sw on the falling edge, then sample just after the next rising edge.
  task automatic step(input logic v);
    @(negedge clk);
    sw = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   ticks;
    int   nb;
    logic db_prev;

    nvec  = 0;
    nerr  = 0;
    ticks = 0;
    rst   = 1'b1;
    sw    = 1'b1;

    // Reset held with sw=1, then rise latency from release.
    #5 rst = 1'b0;
    #1;
    check("reset_async_db", db, 1'b0);
    check("reset_async_busy", busy, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("reset_hold%0d_db", i), db, 1'b0);
      check($sformatf("reset_hold%0d_busy", i), busy, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0 | 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("release_e%0d_db", e), db, (e == 7));
      check($sformatf("release_e%0d_busy", e), busy, (e >= 3 && e <= 6));
    end

    // Reset asserted between edges while in WAIT0.
    step(1'b0);
    step(1'b0);
    step(1'b0);
    check("wait0_db", db, 1'b1);
    check("wait0_busy", busy, 1'b1);
    #4 rst = 1'b0;
    #1;
    check("mid_wait0_reset_db", db, 1'b0);
    check("mid_wait0_reset_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_wait0_hold_db", db, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      check($sformatf("post_reset%0d_db", i), db, 1'b0);
      check($sformatf("post_reset%0d_busy", i), busy, 1'b0);
    end

    // Clean rise and fall.
    add_n(1, 0, 0, 2); add_n(1, 0, 1, 4); add_n(1, 1, 0, 4);
    add_n(0, 1, 0, 2); add_n(0, 1, 1, 4); add_n(0, 0, 0, 4);
    // Bounce 1,0,1,0,1 then hold.
    add(1, 0, 0); add(0, 0, 0); add(1, 0, 1); add(0, 0, 0); add(1, 0, 1);
    add(1, 0, 0); add_n(1, 0, 1, 4); add_n(1, 1, 0, 4);
    add_n(0, 1, 0, 2); add_n(0, 1, 1, 4); add_n(0, 0, 0, 2);
    // 3-cycle glitch from ZERO.
    add(1, 0, 0); add(1, 0, 0); add(1, 0, 1); add(0, 0, 1); add(0, 0, 1);
    add_n(0, 0, 0, 3);
    // Revert exactly at terminal count.
    add(1, 0, 0); add(1, 0, 0); add(1, 0, 1); add(1, 0, 1); add(0, 0, 1);
    add(0, 0, 1); add_n(0, 0, 0, 3);
    // Rise, then 3-cycle glitch from ONE.
    add_n(1, 0, 0, 2); add_n(1, 0, 1, 4); add_n(1, 1, 0, 2);
    add(0, 1, 0); add(0, 1, 0); add(0, 1, 1); add(1, 1, 1); add(1, 1, 1);
    add_n(1, 1, 0, 3);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].sw);
      check($sformatf("vec%0d_db", i), db, vecs[i].db);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
    end

    // Bouncy presses counted by a rising-edge detector on db.
    for (int i = 0; i < 10; i++) step(1'b0);
    check("presses_start_db", db, 1'b0);
    db_prev = db;
    for (int p = 0; p < 20; p++) begin
      nb = int'($urandom_range(1, 3));
      for (int b = 0; b < nb; b++) begin
        step(1'b1);
        if (db && !db_prev) ticks++;
        db_prev = db;
        step(1'b0);
        if (db && !db_prev) ticks++;
        db_prev = db;
      end
      for (int c = 0; c < 10; c++) begin
        step(1'b1);
        if (db && !db_prev) ticks++;
        db_prev = db;
      end
      for (int b = 0; b < nb; b++) begin
        step(1'b0);
        if (db && !db_prev) ticks++;
        db_prev = db;
        step(1'b1);
        if (db && !db_prev) ticks++;
        db_prev = db;
      end
      for (int c = 0; c < 10; c++) begin
        step(1'b0);
        if (db && !db_prev) ticks++;
        db_prev = db;
      end
    end
    nvec++;
    if (ticks != 20) begin
      nerr++;
      $display("FAIL press_ticks: got %0d, expected 20", ticks);
    end
    check("presses_end_db", db, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/debounce_fsm.md
# debounce_fsm

Switch debouncer that turns a raw, bouncing mechanical input into a clean debounced level. It sits directly upstream of the edge detector and drives its `level` input, so the detector emits exactly one `tick` per real press. It consists of a synchronizer, a stability counter and a four-state Moore FSM. The output is registered and glitch-free.

## Interface
- `STABLE_CYCLES`, default 1_000_000: consecutive cycles the synchronized input must hold a new value before `db` follows (20 ms at 50 MHz). Legal range ≥ 2.
- `SYNC_STAGES`, default 2: synchronizer flop count. Legal range ≥ 2.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-low (asserted at 0).
- `sw` in 1: raw switch input, asynchronous to `clk`.
- `db` out 1: debounced level; connects to the edge detector's `level`.
- `busy` out 1: high while a candidate change is being qualified (WAIT1/WAIT0).

## Operation
- `sw` passes through a `SYNC_STAGES`-deep flop chain. The last stage is `sw_s`. FSM and counter see only `sw_s`.
- Counter `cnt` is `$clog2(STABLE_CYCLES)` bits, unsigned.
  - Cleared on every entry to WAIT1 or WAIT0.
  - Increments by 1 each cycle spent in a WAIT state when `cnt != STABLE_CYCLES-1`.
  - Never wraps: the terminal value always forces a state exit.
- States; the encoding is free, but only these four are reachable:
  - ZERO (`db`=0, `busy`=0): `sw_s`=1 goes to WAIT1 with cnt←0; otherwise stay.
  - WAIT1 (`db`=0, `busy`=1):
    - `sw_s`=0 goes to ZERO (bounce rejected).
    - Else, `cnt==STABLE_CYCLES-1` goes to ONE.
    - Else cnt++.
  - ONE (`db`=1, `busy`=0): `sw_s`=0 goes to WAIT0 with cnt←0; otherwise stay.
  - WAIT0 (`db`=1, `busy`=1):
    - `sw_s`=1 goes to ONE (bounce rejected).
    - Else, `cnt==STABLE_CYCLES-1` goes to ZERO.
    - Else cnt++.
- Bounce handling: any return of `sw_s` to the old value during WAIT aborts qualification. `db` does not move. The next opposite value restarts the count from 0.
- `db` and `busy` are decoded from the state register only (Moore). No combinational path from `sw`.

## Timing
- Reset (`rst`=0): asynchronous.
  - Sync flops are cleared to 0, state goes to ZERO, cnt to 0.
  - `db`=0 and `busy`=0 immediately, independent of `clk`.
- Reset release: first active edge is the first rising `clk` with `rst`=1.
- Rise latency: number rising edges from the first edge that samples `sw`=1 as edge 1, with `sw` held high throughout.
  - `sw_s`=1 after edge `SYNC_STAGES`.
  - WAIT1 after edge `SYNC_STAGES+1`.
  - ONE (`db`=1) after edge `SYNC_STAGES+STABLE_CYCLES+1`.
  - With defaults: 1_000_003 edges.
- Fall latency: identical and symmetric, ONE→WAIT0→ZERO.
- `busy` is high for exactly `STABLE_CYCLES` cycles on a clean transition, and 0 in the cycle `db` changes.
- Abort: `sw_s` reverting in WAIT state cycle k returns to the stable state at the next edge. `busy` falls at that edge.
- Boundary: if `sw_s` reverts in the same cycle `cnt==STABLE_CYCLES-1`, the revert wins (abort; `db` unchanged).
- Reset mid-WAIT: immediate return to ZERO with `db`=0, even from WAIT0 where `db` was 1.
- `db` changes at most once per `STABLE_CYCLES+1` cycles; the downstream edge detector sees a clean level.

## Test plan
Bench setup: `STABLE_CYCLES`=4, `SYNC_STAGES`=2, T=20 ns. `sw` is driven on negedge.

- Reset: hold `rst`=0 for 2 cycles with `sw`=1 → `db`=0 and `busy`=0 throughout. After release, `db`=1 after exactly 7 rising edges.
- Clean press: `sw` 0→1 held 20 cycles → `busy`=1 for 4 cycles, then `db`=1 after edge 7. `sw` 1→0 held → `db`=0 after edge 7 of the release.
- Bounce: `sw` toggles 1,0,1,0,1 on successive negedges, then holds 1 → `db` stays 0 during the toggling. `db` rises 7 edges after the final 0→1.
- Short glitch: a 3-cycle `sw`=1 pulse from ZERO → `busy` pulses, `db` stays 0, FSM returns to ZERO.
- Revert at terminal count: `sw_s` drops in the cycle cnt=3 → `db` stays 0.
- Reset mid-WAIT0: from `db`=1, drop `sw`, then assert `rst`=0 two cycles later, between edges → `db`=0 asynchronously. After release with `sw`=0, `db` stays 0.
- Chained with the edge detector: 20 bouncy presses → exactly 20 `tick` pulses.
